shift_lane_sequencer: RTL and testbench

Sequences a warp-wide shift instruction through one shared ALU shift unit, one lane per cycle. Accepts all lanes' operands plus control and active mask in a single valid/ready transfer. Presents the packed per-lane results through a second valid/ready handshake. Sits between the issue stage and ALU writeback in each SIMD core, so one shifter serves every lane.

---
 rtl/alu_pkg.sv | 19 +
 rtl/shift_lane_sequencer_shift.sv | 24 ++
 rtl/shift_lane_sequencer.sv | 142 ++++++++++++++
 tb/tb_shift_lane_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer FSM states, shift-direction control bit, default lane packing.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam int SHR_CTRL_BIT = 4;

  localparam int DEF_NUM_LANES     = 8;
  localparam int DEF_SRC_WIDTH     = 32;
  localparam int DEF_SHAMT_WIDTH   = $clog2(DEF_SRC_WIDTH);
  localparam int DEF_CONTROL_WIDTH = 11;
  localparam int DEF_SRC_BUS_W     = DEF_NUM_LANES * DEF_SRC_WIDTH;
  localparam int DEF_SHAMT_BUS_W   = DEF_NUM_LANES * DEF_SHAMT_WIDTH;

endpackage

// File: rtl/shift_lane_sequencer_shift.sv
// Single-lane ALU shift unit: logical, zero-fill, direction from control bit SHR_CTRL_BIT.
module shift
  import alu_pkg::*;
#(
  parameter int SRC_WIDTH     = 32,
  parameter int SHAMT_WIDTH   = $clog2(SRC_WIDTH),
  parameter int CONTROL_WIDTH = 11
) (
  input  logic [SRC_WIDTH-1:0]     src1,
  input  logic [SHAMT_WIDTH-1:0]   src2,
  input  logic [CONTROL_WIDTH-1:0] control,
  output logic [SRC_WIDTH-1:0]     result
);

  // Only the direction bit matters; the rest of the control word is decoded elsewhere.
  logic unused_ctrl;
  assign unused_ctrl = ^{control[CONTROL_WIDTH-1:SHR_CTRL_BIT+1], control[SHR_CTRL_BIT-1:0]};

  always_comb begin
    if (control[SHR_CTRL_BIT]) result = src1 >> src2;
    else                       result = src1 << src2;
  end

endmodule

// File: rtl/shift_lane_sequencer.sv
// Serialises a warp-wide shift through one shared shift unit, one lane per cycle.
// Optional SHIFT_SEQ_MASK_SKIP_EN: visit only active lanes (lowest index first).
module shift_lane_sequencer
  import alu_pkg::*;
#(
  parameter int NUM_LANES      = 8,
  parameter int SRC_WIDTH      = 32,
  parameter int SHAMT_WIDTH    = $clog2(SRC_WIDTH),
  parameter int CONTROL_WIDTH  = 11,
  parameter int LANE_IDX_WIDTH = $clog2(NUM_LANES)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CONTROL_WIDTH-1:0]         in_control,
  input  logic [NUM_LANES-1:0]             in_mask,
  input  logic [NUM_LANES*SRC_WIDTH-1:0]   in_src1,
  input  logic [NUM_LANES*SHAMT_WIDTH-1:0] in_src2,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_LANES*SRC_WIDTH-1:0]   out_result,
  output logic [NUM_LANES-1:0]             out_mask,
  output logic                             busy
);

  seq_state_e                       state_q, state_d;
  logic [LANE_IDX_WIDTH-1:0]        cnt_q, cnt_d;
  logic [NUM_LANES*SRC_WIDTH-1:0]   src1_q, src1_d;
  logic [NUM_LANES*SHAMT_WIDTH-1:0] src2_q, src2_d;
  logic [CONTROL_WIDTH-1:0]         ctrl_q, ctrl_d;
  logic [NUM_LANES-1:0]             mask_q, mask_d;
  logic [NUM_LANES*SRC_WIDTH-1:0]   res_q, res_d;

  logic [SRC_WIDTH-1:0]      lane_src1;
  logic [SHAMT_WIDTH-1:0]    lane_src2;
  logic [SRC_WIDTH-1:0]      lane_res;
  logic [LANE_IDX_WIDTH-1:0] start_idx;
  logic [LANE_IDX_WIDTH-1:0] step_idx;
  logic                      last_lane;

  assign lane_src1 = src1_q[cnt_q*SRC_WIDTH +: SRC_WIDTH];
  assign lane_src2 = src2_q[cnt_q*SHAMT_WIDTH +: SHAMT_WIDTH];

  shift #(
    .SRC_WIDTH    (SRC_WIDTH),
    .SHAMT_WIDTH  (SHAMT_WIDTH),
    .CONTROL_WIDTH(CONTROL_WIDTH)
  ) u_shift (
    .src1   (lane_src1),
    .src2   (lane_src2),
    .control(ctrl_q),
    .result (lane_res)
  );

`ifdef SHIFT_SEQ_MASK_SKIP_EN
  logic [LANE_IDX_WIDTH-1:0] first_idx;
  logic [LANE_IDX_WIDTH-1:0] next_idx;
  logic                      has_next;

  // Scanning downwards leaves the lowest qualifying index in each result.
  always_comb begin
    first_idx = '0;
    next_idx  = cnt_q;
    has_next  = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (in_mask[i]) first_idx = LANE_IDX_WIDTH'(i);
      if (mask_q[i] && (LANE_IDX_WIDTH'(i) > cnt_q)) begin
        next_idx = LANE_IDX_WIDTH'(i);
        has_next = 1'b1;
      end
    end
  end

  assign start_idx = first_idx;
  assign step_idx  = next_idx;
  assign last_lane = !has_next;
`else
  assign start_idx = '0;
  assign step_idx  = cnt_q + 1'b1;
  assign last_lane = (cnt_q == LANE_IDX_WIDTH'(NUM_LANES - 1));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    ctrl_d  = ctrl_q;
    mask_d  = mask_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          src1_d  = in_src1;
          src2_d  = in_src2;
          ctrl_d  = in_control;
          mask_d  = in_mask;
          res_d   = '0;
          cnt_d   = start_idx;
          state_d = RUN;
        end
      end
      RUN: begin
        if (mask_q[cnt_q]) res_d[cnt_q*SRC_WIDTH +: SRC_WIDTH] = lane_res;
        if (last_lane) state_d = DONE;
        else           cnt_d   = step_idx;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      ctrl_q  <= '0;
      mask_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      ctrl_q  <= ctrl_d;
      mask_q  <= mask_d;
      res_q   <= res_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_result = res_q;
  assign out_mask   = mask_q;

endmodule

// File: tb/tb_shift_lane_sequencer.sv
// Directed self-checking bench for shift_lane_sequencer (8 lanes x 32 bits).
module tb_shift_lane_sequencer;

  localparam int NL = 8;
  localparam int SW = 32;
  localparam int AW = 5;
  localparam int CW = 11;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [CW-1:0]     in_control;
  logic [NL-1:0]     in_mask;
  logic [NL*SW-1:0]  in_src1;
  logic [NL*AW-1:0]  in_src2;
  logic              out_valid;
  logic              out_ready;
  logic [NL*SW-1:0]  out_result;
  logic [NL-1:0]     out_mask;
  logic              busy;

  int checks;
  int failures;

  logic [SW-1:0] s1 [NL];
  logic [AW-1:0] s2 [NL];
  logic [SW-1:0] ex [NL];
  logic [NL*SW-1:0] exp_vec;

  shift_lane_sequencer #(
    .NUM_LANES    (NL),
    .SRC_WIDTH    (SW),
    .SHAMT_WIDTH  (AW),
    .CONTROL_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_control(in_control),
    .in_mask   (in_mask),
    .in_src1   (in_src1),
    .in_src2   (in_src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_mask  (out_mask),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_latency(input logic [NL-1:0] m);
`ifdef SHIFT_SEQ_MASK_SKIP_EN
    return ($countones(m) == 0) ? 1 : $countones(m);
`else
    return (m == m) ? NL : NL;
`endif
  endfunction

  task automatic pack_expected();
    for (int i = 0; i < NL; i++) exp_vec[i*SW +: SW] = ex[i];
  endtask

  // Presents one request; acc reports in_ready as seen just before the edge.
  task automatic send_req(input logic [NL-1:0] m, input logic [CW-1:0] c, output logic acc);
    @(negedge clk);
    for (int i = 0; i < NL; i++) begin
      in_src1[i*SW +: SW] = s1[i];
      in_src2[i*AW +: AW] = s2[i];
    end
    in_mask    = m;
    in_control = c;
    in_valid   = 1'b1;
    acc        = in_ready;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_src1    = '1;
    in_src2    = '1;
    in_mask    = ~m;
    in_control = ~c;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!out_valid && edges < 40);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== '0 || out_mask !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b busy=%b result=%h mask=%h, want all 0",
               out_valid, busy, out_result, out_mask);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    $display("txn reset: valid=%b busy=%b in_ready=%b", out_valid, busy, in_ready);
  endtask

  task automatic test_left_all();
    logic acc;
    int   e;
    for (int i = 0; i < NL; i++) begin
      s1[i] = 32'h1;
      s2[i] = AW'(i);
      ex[i] = 32'h1 << i;
    end
    pack_expected();
    send_req(8'hFF, 11'h7EF, acc);
    checks++;
    if (acc !== 1'b1) begin failures++; $display("FAIL left_accept: in_ready=%b want 1", acc); end
    wait_valid(e);
    checks++;
    if (e != NL) begin failures++; $display("FAIL left_latency: got %0d want %0d", e, NL); end
    checks++;
    if (out_result !== exp_vec || out_mask !== 8'hFF) begin
      failures++;
      $display("FAIL left_result: got %h/%h want %h/ff", out_result, out_mask, exp_vec);
    end
    $display("txn left_all: latency=%0d result=%h mask=%h", e, out_result, out_mask);
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL left_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_right_backpressure();
    logic acc;
    int   e;
    s1[0] = 32'h8000_0000; s2[0] = 5'd31; ex[0] = 32'h0000_0001;
    s1[1] = 32'hF0F0_F0F0; s2[1] = 5'd0;  ex[1] = 32'hF0F0_F0F0;
    s1[2] = 32'hF0F0_F0F0; s2[2] = 5'd4;  ex[2] = 32'h0F0F_0F0F;
    s1[3] = 32'hDEAD_BEEF; s2[3] = 5'd8;  ex[3] = 32'h00DE_ADBE;
    s1[4] = 32'hFFFF_FFFF; s2[4] = 5'd1;  ex[4] = 32'h7FFF_FFFF;
    s1[5] = 32'h1234_5678; s2[5] = 5'd16; ex[5] = 32'h0000_1234;
    s1[6] = 32'h0000_0001; s2[6] = 5'd1;  ex[6] = 32'h0000_0000;
    s1[7] = 32'hABCD_0000; s2[7] = 5'd28; ex[7] = 32'h0000_000A;
    pack_expected();
    send_req(8'hFF, 11'h7FF, acc);
    wait_valid(e);
    checks++;
    if (out_result !== exp_vec) begin
      failures++;
      $display("FAIL right_result: got %h want %h", out_result, exp_vec);
    end
    $display("txn right: latency=%0d result=%h", e, out_result);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = k[0];
      in_src1  = {NL{32'h5A5A_0000 + 32'(k)}};
      in_mask  = 8'(k);
      checks++;
      if (out_result !== exp_vec || out_mask !== 8'hFF || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL backpressure_hold: cyc=%0d result=%h mask=%h in_ready=%b valid=%b want %h/ff/0/1",
                 k, out_result, out_mask, in_ready, out_valid, exp_vec);
      end
    end
    in_valid = 1'b0;
    release_out();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release: in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
    $display("txn backpressure: held 5 cycles, in_ready=%b", in_ready);
  endtask

  task automatic test_partial_mask();
    logic acc;
    int   e;
    for (int i = 0; i < NL; i++) begin
      s1[i] = 32'hFFFF_FFFF; s2[i] = 5'd1; ex[i] = 32'h0;
    end
    s1[0] = 32'h0000_00A5; s2[0] = 5'd4;  ex[0] = 32'h0000_0A50;
    s1[2] = 32'h0000_0001; s2[2] = 5'd31; ex[2] = 32'h8000_0000;
    pack_expected();
    send_req(8'h05, 11'h000, acc);
    wait_valid(e);
    checks++;
    if (e != exp_latency(8'h05)) begin
      failures++;
      $display("FAIL partial_latency: got %0d want %0d", e, exp_latency(8'h05));
    end
    checks++;
    if (out_result !== exp_vec || out_mask !== 8'h05) begin
      failures++;
      $display("FAIL partial_result: got %h/%h want %h/05", out_result, out_mask, exp_vec);
    end
    $display("txn partial: latency=%0d result=%h mask=%h", e, out_result, out_mask);
    release_out();
  endtask

  task automatic test_reset_mid_run();
    logic acc;
    int   e;
    for (int i = 0; i < NL; i++) begin
      s1[i] = 32'hFFFF_FFFF; s2[i] = 5'd0;
    end
    send_req(8'hFF, 11'h000, acc);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== '0) begin
      failures++;
      $display("FAIL midrun_reset: valid=%b busy=%b result=%h want 0/0/0", out_valid, busy, out_result);
    end
    $display("txn midrun_reset: valid=%b busy=%b result=%h", out_valid, busy, out_result);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NL; i++) begin
      s1[i] = 32'h3; s2[i] = AW'(i); ex[i] = (i >= 4) ? (32'h3 << i) : 32'h0;
    end
    pack_expected();
    send_req(8'hF0, 11'h000, acc);
    wait_valid(e);
    checks++;
    if (out_result !== exp_vec || out_mask !== 8'hF0) begin
      failures++;
      $display("FAIL midrun_recover: got %h/%h want %h/f0", out_result, out_mask, exp_vec);
    end
    $display("txn midrun_recover: latency=%0d result=%h", e, out_result);
    release_out();
  endtask

  task automatic test_zero_mask();
    logic acc;
    int   e;
    for (int i = 0; i < NL; i++) begin
      s1[i] = 32'hFFFF_FFFF; s2[i] = 5'd3; ex[i] = 32'h0;
    end
    send_req(8'h00, 11'h7FF, acc);
    wait_valid(e);
    checks++;
    if (e != exp_latency(8'h00)) begin
      failures++;
      $display("FAIL zero_latency: got %0d want %0d", e, exp_latency(8'h00));
    end
    checks++;
    if (out_result !== '0 || out_mask !== 8'h00) begin
      failures++;
      $display("FAIL zero_result: got %h/%h want 0/00", out_result, out_mask);
    end
    $display("txn zero_mask: latency=%0d result=%h", e, out_result);
    release_out();
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   e;
    for (int i = 0; i < NL; i++) begin
      s1[i] = 32'h0000_0100; s2[i] = AW'(i); ex[i] = 32'h0000_0100 >> i;
    end
    pack_expected();
    send_req(8'hFF, 11'h010, acc);
    wait_valid(e);
    @(negedge clk);
    for (int i = 0; i < NL; i++) begin
      in_src1[i*SW +: SW] = s1[i];
      in_src2[i*AW +: AW] = s2[i];
    end
    in_mask    = 8'hFF;
    in_control = 11'h7EF;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_overlap: in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b in_ready=%b want 1/0", busy, in_ready);
    end
    for (int i = 0; i < NL; i++) ex[i] = 32'h0000_0100 << i;
    pack_expected();
    wait_valid(e);
    checks++;
    if (e != NL || out_result !== exp_vec) begin
      failures++;
      $display("FAIL b2b_result: latency=%0d result=%h want %0d/%h", e, out_result, NL, exp_vec);
    end
    $display("txn back_to_back: latency=%0d result=%h", e, out_result);
    release_out();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_control = '0;
    in_mask    = '0;
    in_src1    = '0;
    in_src2    = '0;
    rst_n      = 1'b0;
    test_reset();
    test_left_all();
    test_right_backpressure();
    test_partial_mask();
    test_reset_mid_run();
    test_zero_mask();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
